// File: rtl/frequency_generator.sv
// Programmable square-wave source. An accumulator NCO divides the system
// clock by an arbitrary (including non-integer) ratio, so the long-run
// output frequency is exact. An optional LFSR-driven bounce window after
// each clean edge emulates contact chatter for exercising debounce logic.
module frequency_generator #(
    parameter int unsigned CLK_HZ        = 25_000_000,
    parameter int unsigned FREQ_W        = 24,
    parameter int unsigned ACC_W         = 32,
    parameter int unsigned BOUNCE_CYCLES = 10,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic [FREQ_W-1:0] iFrecuencia,
    input  logic              iCargar,
    input  logic              iRuido,
    output logic              oSenal,
    output logic              oFlanco,
    output logic              oActivo,
    output logic [CNT_W-1:0]  oPeriodos
);

    typedef enum logic [1:0] {IDLE, RUN, BOUNCE} state_t;

    localparam int unsigned    AW1    = ACC_W + 1;
    localparam int unsigned    BC_W   = $clog2(BOUNCE_CYCLES + 1);
    localparam logic [ACC_W:0] CLK_V  = AW1'(CLK_HZ);
    localparam logic [ACC_W:0] HALF_V = AW1'(CLK_HZ / 2);

    state_t            state, state_n;
    logic [FREQ_W-1:0] frec, frec_n;
    logic [ACC_W-1:0]  acc, acc_n;
    logic              level, level_n;
    logic [15:0]       lfsr, lfsr_n;
    logic [BC_W-1:0]   bcnt, bcnt_n;
    logic              senal_n, flanco_n, activo_n;
    logic [CNT_W-1:0]  periodos_n;

    logic [ACC_W:0]    sum;
    logic [FREQ_W-1:0] clamped;
    logic              toggle, noisy;

    // Next-state, accumulator, bounce window and registered-output values.
    always_comb begin
        state_n    = state;
        frec_n     = frec;
        acc_n      = acc;
        level_n    = level;
        bcnt_n     = bcnt;
        flanco_n   = 1'b0;
        periodos_n = oPeriodos;
        toggle     = 1'b0;
        noisy      = 1'b0;
        lfsr_n     = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        sum        = {1'b0, acc} + (AW1'(frec) << 1);
        clamped    = (AW1'(iFrecuencia) > HALF_V) ? FREQ_W'(HALF_V) : iFrecuencia;

        if (iCargar) begin
            // Load wins over any toggle due this cycle; timing restarts here.
            frec_n  = clamped;
            acc_n   = '0;
            level_n = 1'b0;
            bcnt_n  = '0;
            state_n = (clamped == '0) ? IDLE : RUN;
        end else begin
            case (state)
                IDLE: begin
                    level_n = 1'b0;
                end
                RUN, BOUNCE: begin
                    if (sum >= CLK_V) begin
                        acc_n    = ACC_W'(sum - CLK_V);
                        level_n  = ~level;
                        flanco_n = 1'b1;
                        toggle   = 1'b1;
                        if (!level)
                            periodos_n = oPeriodos + CNT_W'(1);
                    end else begin
                        acc_n = ACC_W'(sum);
                    end

                    // A toggle (re)opens the window; the toggle cycle itself stays clean.
                    if (toggle && iRuido) begin
                        state_n = BOUNCE;
                        bcnt_n  = BC_W'(BOUNCE_CYCLES);
                    end else if (state == BOUNCE) begin
                        if (!iRuido || bcnt == '0) begin
                            state_n = RUN;
                            bcnt_n  = '0;
                        end else begin
                            bcnt_n = bcnt - BC_W'(1);
                            noisy  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        senal_n  = noisy ? lfsr_n[0] : level_n;
        activo_n = (state_n != IDLE);
    end

    // State and output registers; reset aborts any period in progress.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= IDLE;
            frec      <= '0;
            acc       <= '0;
            level     <= 1'b0;
            lfsr      <= LFSR_SEED;
            bcnt      <= '0;
            oSenal    <= 1'b0;
            oFlanco   <= 1'b0;
            oActivo   <= 1'b0;
            oPeriodos <= '0;
        end else begin
            state     <= state_n;
            frec      <= frec_n;
            acc       <= acc_n;
            level     <= level_n;
            lfsr      <= lfsr_n;
            bcnt      <= bcnt_n;
            oSenal    <= senal_n;
            oFlanco   <= flanco_n;
            oActivo   <= activo_n;
            oPeriodos <= periodos_n;
        end
    end

endmodule

// File: tb/tb_frequency_generator.sv
// Directed bench: reset/idle, exact NCO division, clamp/zero load,
// bounce window against a reference LFSR, reload/reset mid-run, counter wrap.
module tb_frequency_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] frec;
    logic        cargar, ruido;
    logic        senal, flanco, activo;
    logic [15:0] periodos;

    logic [23:0] w_frec;
    logic        w_cargar, w_ruido;
    logic        w_senal, w_flanco, w_activo;
    logic [3:0]  w_periodos;

    logic [15:0] m_lfsr;

    int total = 0;
    int bad   = 0;

    frequency_generator #(.CLK_HZ(25_000_000), .FREQ_W(24), .ACC_W(32),
                          .BOUNCE_CYCLES(10), .LFSR_SEED(16'hACE1), .CNT_W(16)) u_dut (
        .iClk(clk), .iRst_n(rst_n), .iFrecuencia(frec), .iCargar(cargar), .iRuido(ruido),
        .oSenal(senal), .oFlanco(flanco), .oActivo(activo), .oPeriodos(periodos)
    );

    frequency_generator #(.CNT_W(4)) u_wrap (
        .iClk(clk), .iRst_n(rst_n), .iFrecuencia(w_frec), .iCargar(w_cargar), .iRuido(w_ruido),
        .oSenal(w_senal), .oFlanco(w_flanco), .oActivo(w_activo), .oPeriodos(w_periodos)
    );

    always #5 clk = ~clk;

    // Reference 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting every clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [23:0] v);
        frec   = v;
        cargar = 1'b1;
        tick();
        cargar = 1'b0;
    endtask

    task automatic wait_flanco(input int budget, output int gap);
        gap = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (flanco) begin
                gap = i;
                break;
            end
        end
    endtask

    initial begin
        int          gap, nfl;
        int          et[4];
        logic [15:0] p0, p1;
        logic        lvl;

        rst_n = 1'b0; frec = '0; cargar = 1'b0; ruido = 1'b0;
        w_frec = '0; w_cargar = 1'b0; w_ruido = 1'b0;

        // Reset and idle
        repeat (5) tick();
        check("rst_senal",    32'(senal),    0);
        check("rst_flanco",   32'(flanco),   0);
        check("rst_activo",   32'(activo),   0);
        check("rst_periodos", 32'(periodos), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_senal",    32'(senal),    0);
            check("idle_activo",   32'(activo),   0);
            check("idle_periodos", 32'(periodos), 0);
        end

        // Exact division at 1 MHz: half-periods 13,12,13,12...
        load(24'd1_000_000);
        check("exact_activo", 32'(activo), 1);
        p0  = periodos;
        nfl = 0;
        foreach (et[k]) et[k] = 0;
        for (int t = 1; t <= 25000; t++) begin
            tick();
            if (flanco) begin
                if (nfl < 4) et[nfl] = t;
                nfl++;
            end
        end
        check("exact_first", 32'(et[0]), 13);
        check("exact_edge2", 32'(et[1]), 25);
        check("exact_edge3", 32'(et[2]), 38);
        check("exact_edge4", 32'(et[3]), 50);
        check("exact_count", 32'(nfl), 2000);
        check("exact_periodos", 32'(16'(periodos - p0)), 1000);
        check("exact_end_level", 32'(senal), 0);

        // Clamp: above CLK_HZ/2 toggles every clock
        p0 = periodos;
        load(24'hFF_FFFF);
        check("clamp_activo", 32'(activo), 1);
        check("clamp_senal0", 32'(senal), 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("clamp_senal",  32'(senal),  32'(i % 2));
            check("clamp_flanco", 32'(flanco), 1);
        end
        p1 = periodos;
        check("clamp_periodos", 32'(16'(p1 - p0)), 5);

        // Zero load stops output, keeps the period count
        load(24'd0);
        check("zero_senal",    32'(senal),    0);
        check("zero_activo",   32'(activo),   0);
        check("zero_periodos", 32'(periodos), 32'(p1));
        repeat (5) tick();
        check("zero_hold", 32'(senal), 0);

        // Bounce at 100 kHz: 10 noisy clocks after each toggle, 115 clean
        ruido = 1'b1;
        load(24'd100_000);
        wait_flanco(200, gap);
        check("bounce_first", 32'(gap), 125);
        lvl = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("bounce_toggle_clean", 32'(senal), 32'(lvl));
            for (int i = 1; i <= 10; i++) begin
                tick();
                check("bounce_noise", 32'(senal), 32'(m_lfsr[0]));
            end
            for (int i = 11; i <= 124; i++) begin
                tick();
                check("bounce_stable", 32'(senal),  32'(lvl));
                check("bounce_noflanco", 32'(flanco), 0);
            end
            tick();
            check("bounce_period", 32'(flanco), 1);
            lvl = ~lvl;
        end
        tick();
        ruido = 1'b0;
        tick();
        check("ruido_drop", 32'(senal), 32'(lvl));

        // Load coinciding with a due toggle
        load(24'd1_000_000);
        repeat (12) tick();
        frec = 24'd1_000_000; cargar = 1'b1;
        tick();
        cargar = 1'b0;
        check("reload_noflanco", 32'(flanco), 0);
        check("reload_senal",    32'(senal),  0);
        wait_flanco(40, gap);
        check("reload_restart", 32'(gap), 13);
        check("reload_level",   32'(senal), 1);

        // Asynchronous reset mid-period
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_senal",    32'(senal),    0);
        check("areset_flanco",   32'(flanco),   0);
        check("areset_activo",   32'(activo),   0);
        check("areset_periodos", 32'(periodos), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Period counter wrap with a 4-bit counter
        w_frec = 24'hFF_FFFF; w_cargar = 1'b1;
        tick();
        w_cargar = 1'b0;
        repeat (32) tick();
        check("wrap_16", 32'(w_periodos), 0);
        tick();
        check("wrap_17", 32'(w_periodos), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
